ps2_keyboard_rx: RTL and testbench
==================================

Name: ps2_keyboard_rx

Overview:
Player-input end of the typing game. Receives PS/2 Set-2 frames from the keyboard on PS2_CLK/PS2_DAT and checks framing and parity. Strips break (F0) and extended (E0) prefixes and translates make codes to ASCII. Queues {scan_code, ascii} pairs in a small FIFO that the game logic pops when it is ready to match keystrokes against the falling characters. Runs on the 50 MHz system clock.

Parameters:
FIFO_AW, 3, FIFO address width; depth = 2^FIFO_AW entries (default 8).
TIMEOUT, 50000, clk cycles without a PS/2 falling edge before a partial frame is discarded (1 ms at 50 MHz).

Ports:
clk  input  1  system clock (CLOCK_50).
rst  input  1  asynchronous, active-high reset.
ps2_clk  input  1  raw PS/2 clock line, asynchronous to clk.
ps2_data  input  1  raw PS/2 data line, asynchronous to clk.
rd_en  input  1  pop strobe; acts only when ready=1.
ready  output  1  FIFO non-empty.
scan_code  output  8  head-entry make code; 0 when ready=0.
ascii  output  8  head-entry ASCII; 0 when ready=0 or the key is unmapped.
overflow  output  1  sticky; set when a push is dropped because the FIFO is full.
frame_err  output  1  one-cycle pulse on parity error, stop-bit error or timeout.

Behaviour:
- Reset (async, rst=1):
  - Outputs: ready=0, scan_code=0, ascii=0, overflow=0, frame_err=0.
  - Internal: FSM to IDLE; bit counter, break flag, ext flag and FIFO pointers/count cleared.
  - Reset mid-frame discards all partial data.
- Synchroniser:
  - ps2_clk passes through a 3-flop shift register; a falling edge is registered when stages [2:1]==2'b10.
  - ps2_data passes through 2 flops and is sampled only in falling-edge cycles.
- Frame FSM (advances on falling edges only):
  - IDLE: data=0 -> DATA with bitcnt=0; data=1 -> stay IDLE (glitch, ignored).
  - DATA: shift bits in LSB-first; after the 8th bit -> PARITY.
  - PARITY: store the bit -> STOP.
  - STOP: if stop=1 and XOR(data[7:0], parity)=1 (odd parity), pulse byte_valid for 1 cycle; otherwise pulse frame_err. Always -> IDLE.
- Timeout:
  - In any state other than IDLE, a counter increments every clk and clears on each falling edge.
  - When it reaches TIMEOUT-1: discard the frame, go to IDLE, pulse frame_err.
- Decoder (on byte_valid):
  - F0: set brk; no push.
  - E0: set ext; no push.
  - Any other byte with brk=1: clear brk and ext; no push (key release).
  - Any other byte with brk=0: push {byte, ascii}, where ascii=0 if ext=1; then clear ext.
  - Typematic repeats are pushed every time.
- ASCII map, Set-2 code -> ASCII:
  - Letters (uppercase): 1C A, 32 B, 21 C, 23 D, 24 E, 2B F, 34 G, 33 H, 43 I, 3B J, 42 K, 4B L, 3A M, 31 N, 44 O, 4D P, 15 Q, 2D R, 1B S, 2C T, 3C U, 2A V, 1D W, 22 X, 35 Y, 1A Z.
  - Digits: 45 '0', 16 '1', 1E '2', 26 '3', 25 '4', 2E '5', 36 '6', 3D '7', 3E '8', 46 '9'.
  - Controls: 29 -> 0x20, 5A -> 0x0D, 66 -> 0x08.
  - All other codes -> 0x00.
- Latency: if the stop-bit falling edge is registered in cycle N, byte_valid is high in N+1, the push happens at the end of N+1, and ready=1 from N+2.
- FIFO (show-ahead):
  - Head entry is visible on scan_code/ascii while ready=1.
  - rd_en with ready=1 pops at the clock edge; rd_en with ready=0 is ignored.
  - Push when full, no pop: entry dropped, overflow<=1, held until rst.
  - Simultaneous push and pop when full: both occur, count unchanged, overflow not set.
  - Push and rd_en when empty: push only; ready rises next cycle.
  - Pointers wrap modulo 2^FIFO_AW.
- Bench constraint: PS/2 half-period >= 8 clk cycles.

Test Plan:
1. Frame 0x1C (parity bit 0, stop 1) -> ready=1 within 2 cycles of the stop edge, scan_code=0x1C, ascii=0x41; 1-cycle rd_en -> ready=0, scan_code=0, ascii=0.
2. Sequence 1C, F0, 1C, with one pop after the first byte -> exactly one entry popped; after F0 1C, ready stays 0 and frame_err never pulses.
3. E0 75, then E0 F0 75 -> single entry scan_code=0x75, ascii=0x00; the release pushes nothing; a following 0x16 gives ascii=0x31 (ext cleared).
4. Frame 0x1C with parity bit 1 -> frame_err high exactly 1 cycle, no push; next clean 0x32 -> ascii=0x42.
5. Nine make codes 15,1D,24,2D,2C,35,3C,43,44 with no pops -> overflow=1 after the 9th; 8 pops return Q,W,E,R,T,Y,U,I in order; 0x44 absent. Separately, a push coinciding with a pop on a full FIFO -> no overflow.
6. Start bit plus 4 data bits, then silence -> frame_err pulse at TIMEOUT cycles after the last edge, FSM in IDLE; next full frame 0x45 -> ascii=0x30. Assert rst mid-frame -> all outputs 0 immediately.

Source files
------------

// File: rtl/ps2_keyboard_rx_if.sv
// Read-side bundle of the PS/2 keyboard receiver: the game logic pops decoded
// keystrokes and watches the error and overflow status.
interface ps2_keyboard_rx_if;
  logic       rd_en;
  logic       ready;
  logic [7:0] scan_code;
  logic [7:0] ascii;
  logic       overflow;
  logic       frame_err;

  modport master (
    output rd_en,
    input  ready, scan_code, ascii, overflow, frame_err
  );

  modport slave (
    input  rd_en,
    output ready, scan_code, ascii, overflow, frame_err
  );
endinterface

// File: rtl/ps2_keyboard_rx.sv
// PS/2 Set-2 keyboard receiver: synchronises the raw lines, deframes 11-bit
// frames with odd parity, strips F0/E0 prefixes, maps make codes to ASCII and
// queues {scan_code, ascii} pairs in a show-ahead FIFO.
module ps2_keyboard_rx #(
  parameter int FIFO_AW = 3,
  parameter int TIMEOUT = 50000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               ps2_clk,
  input  logic               ps2_data,
  ps2_keyboard_rx_if.slave   rx
);

  localparam int DEPTH = 1 << FIFO_AW;
  localparam int TW    = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0]      TO_LAST = TW'(TIMEOUT - 1);
  localparam logic [FIFO_AW:0]   FULL_CNT = (FIFO_AW + 1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  function automatic logic [7:0] ascii_of(input logic [7:0] code);
    case (code)
      8'h1C: ascii_of = 8'h41; 8'h32: ascii_of = 8'h42; 8'h21: ascii_of = 8'h43;
      8'h23: ascii_of = 8'h44; 8'h24: ascii_of = 8'h45; 8'h2B: ascii_of = 8'h46;
      8'h34: ascii_of = 8'h47; 8'h33: ascii_of = 8'h48; 8'h43: ascii_of = 8'h49;
      8'h3B: ascii_of = 8'h4A; 8'h42: ascii_of = 8'h4B; 8'h4B: ascii_of = 8'h4C;
      8'h3A: ascii_of = 8'h4D; 8'h31: ascii_of = 8'h4E; 8'h44: ascii_of = 8'h4F;
      8'h4D: ascii_of = 8'h50; 8'h15: ascii_of = 8'h51; 8'h2D: ascii_of = 8'h52;
      8'h1B: ascii_of = 8'h53; 8'h2C: ascii_of = 8'h54; 8'h3C: ascii_of = 8'h55;
      8'h2A: ascii_of = 8'h56; 8'h1D: ascii_of = 8'h57; 8'h22: ascii_of = 8'h58;
      8'h35: ascii_of = 8'h59; 8'h1A: ascii_of = 8'h5A;
      8'h45: ascii_of = 8'h30; 8'h16: ascii_of = 8'h31; 8'h1E: ascii_of = 8'h32;
      8'h26: ascii_of = 8'h33; 8'h25: ascii_of = 8'h34; 8'h2E: ascii_of = 8'h35;
      8'h36: ascii_of = 8'h36; 8'h3D: ascii_of = 8'h37; 8'h3E: ascii_of = 8'h38;
      8'h46: ascii_of = 8'h39;
      8'h29: ascii_of = 8'h20; 8'h5A: ascii_of = 8'h0D; 8'h66: ascii_of = 8'h08;
      default: ascii_of = 8'h00;
    endcase
  endfunction

  logic [2:0]         ps2c_q;
  logic [1:0]         ps2d_q;
  state_t             state_q, state_d;
  logic [2:0]         bitcnt_q, bitcnt_d;
  logic [TW-1:0]      tocnt_q;
  logic [7:0]         shift_q;
  logic               par_q;
  logic               bv_q, bv_d;
  logic               ferr_q, ferr_d;
  logic               brk_q, ext_q;
  logic               ovf_q;
  logic [FIFO_AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [FIFO_AW:0]   count_q;
  logic [15:0]        mem [DEPTH];

  logic fall, din, timeout;
  logic is_f0, is_e0, push_req, full, pop, push_ok;

  assign fall    = (ps2c_q[2:1] == 2'b10);
  assign din     = ps2d_q[1];
  assign timeout = (state_q != IDLE) && !fall && (tocnt_q == TO_LAST);

  // Synchronise the PS/2 lines; idle-high reset value avoids a false edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ps2c_q <= 3'b111;
      ps2d_q <= 2'b11;
    end else begin
      ps2c_q <= {ps2c_q[1:0], ps2_clk};
      ps2d_q <= {ps2d_q[0], ps2_data};
    end
  end

  // Frame FSM state, bit counter, status pulses and inactivity counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      bitcnt_q <= '0;
      bv_q     <= 1'b0;
      ferr_q   <= 1'b0;
      tocnt_q  <= '0;
    end else begin
      state_q  <= state_d;
      bitcnt_q <= bitcnt_d;
      bv_q     <= bv_d;
      ferr_q   <= ferr_d;
      if (state_q == IDLE || fall) tocnt_q <= '0;
      else                         tocnt_q <= tocnt_q + TW'(1);
    end
  end

  // Frame FSM next state: advances on PS/2 falling edges, aborts on timeout.
  always_comb begin
    state_d  = state_q;
    bitcnt_d = bitcnt_q;
    bv_d     = 1'b0;
    ferr_d   = 1'b0;
    if (timeout) begin
      state_d = IDLE;
      ferr_d  = 1'b1;
    end else if (fall) begin
      case (state_q)
        IDLE: if (!din) begin
          state_d  = DATA;
          bitcnt_d = '0;
        end
        DATA: begin
          bitcnt_d = bitcnt_q + 3'd1;
          if (bitcnt_q == 3'd7) state_d = PARITY;
        end
        PARITY: state_d = STOP;
        STOP: begin
          if (din && (^{shift_q, par_q})) bv_d   = 1'b1;
          else                            ferr_d = 1'b1;
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Data bits shift in LSB-first; the byte stays put until the next frame's data.
  always_ff @(posedge clk) begin
    if (fall && state_q == DATA)   shift_q <= {din, shift_q[7:1]};
    if (fall && state_q == PARITY) par_q   <= din;
  end

  assign is_f0    = (shift_q == 8'hF0);
  assign is_e0    = (shift_q == 8'hE0);
  assign push_req = bv_q && !is_f0 && !is_e0 && !brk_q;
  assign full     = (count_q == FULL_CNT);
  assign pop      = rx.rd_en && (count_q != '0);
  assign push_ok  = push_req && (!full || pop);

  // Prefix tracking: F0 marks a release, E0 an extended key.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      brk_q <= 1'b0;
      ext_q <= 1'b0;
    end else if (bv_q) begin
      if (is_f0)      brk_q <= 1'b1;
      else if (is_e0) ext_q <= 1'b1;
      else begin
        brk_q <= 1'b0;
        ext_q <= 1'b0;
      end
    end
  end

  // FIFO pointers, occupancy and sticky overflow.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + FIFO_AW'(1);
      if (pop)     rd_ptr_q <= rd_ptr_q + FIFO_AW'(1);
      case ({push_ok, pop})
        2'b10:   count_q <= count_q + (FIFO_AW + 1)'(1);
        2'b01:   count_q <= count_q - (FIFO_AW + 1)'(1);
        default: count_q <= count_q;
      endcase
      if (push_req && full && !pop) ovf_q <= 1'b1;
    end
  end

  // FIFO storage; extended keys carry no ASCII.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr_q] <= {shift_q, (ext_q ? 8'h00 : ascii_of(shift_q))};
  end

  assign rx.ready     = (count_q != '0);
  assign rx.scan_code = rx.ready ? mem[rd_ptr_q][15:8] : 8'h00;
  assign rx.ascii     = rx.ready ? mem[rd_ptr_q][7:0]  : 8'h00;
  assign rx.overflow  = ovf_q;
  assign rx.frame_err = ferr_q;

endmodule

// File: tb/tb_ps2_keyboard_rx.sv
// Directed bench for ps2_keyboard_rx: drives PS/2 frames bit by bit and checks
// the FIFO read side against hand-computed values.
module tb_ps2_keyboard_rx;
  localparam int TO = 300;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic ps2_clk = 1'b1;
  logic ps2_data = 1'b1;

  ps2_keyboard_rx_if rx_if ();

  ps2_keyboard_rx #(.FIFO_AW(3), .TIMEOUT(TO)) dut (
    .clk      (clk),
    .rst      (rst),
    .ps2_clk  (ps2_clk),
    .ps2_data (ps2_data),
    .rx       (rx_if.slave)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_fail  = 0;
  int lat     = 0;
  int ferr_cnt = 0;

  // Count every cycle in which frame_err is observed high.
  always @(posedge clk) begin
    #1;
    if (rx_if.frame_err === 1'b1) ferr_cnt++;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: observed no finish, required finish within time limit");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic pop1();
    @(negedge clk); rx_if.rd_en = 1'b1;
    @(negedge clk); rx_if.rd_en = 1'b0;
  endtask

  // One PS/2 bit: data set while clock high, clock low for 10 cycles.
  task automatic ps2_bit(input logic b, input bit is_stop, input bit pop_at_push);
    @(negedge clk); ps2_data = b;
    repeat (4) @(negedge clk);
    ps2_clk = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      @(posedge clk); #1;
      if (is_stop && lat == 0 && rx_if.ready === 1'b1) lat = i;
      if (pop_at_push && i == 4) rx_if.rd_en = 1'b0;
      if (pop_at_push && i == 3) begin
        @(negedge clk); rx_if.rd_en = 1'b1;
      end
    end
    @(negedge clk); ps2_clk = 1'b1;
    repeat (9) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit pop_at_push);
    lat = 0;
    ps2_bit(1'b0, 0, 0);
    for (int i = 0; i < 8; i++) ps2_bit(b[i], 0, 0);
    ps2_bit((~^b) ^ bad_par, 0, 0);
    ps2_bit(1'b1, 1, pop_at_push);
  endtask

  logic [7:0] codes [9] = '{8'h15, 8'h1D, 8'h24, 8'h2D, 8'h2C, 8'h35, 8'h3C, 8'h43, 8'h44};
  logic [7:0] chars [9] = '{8'h51, 8'h57, 8'h45, 8'h52, 8'h54, 8'h59, 8'h55, 8'h49, 8'h4F};
  int base;
  int t;

  initial begin
    rx_if.rd_en = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_ready", rx_if.ready, 0);
    chk("rst_scan", rx_if.scan_code, 0);
    chk("rst_ascii", rx_if.ascii, 0);
    chk("rst_ovf", rx_if.overflow, 0);
    chk("rst_ferr", rx_if.frame_err, 0);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    // 1: basic make code, latency and pop
    send_frame(8'h1C, 0, 0);
    chk("t1_latency", lat, 4);
    chk("t1_ready", rx_if.ready, 1);
    chk("t1_scan", rx_if.scan_code, 8'h1C);
    chk("t1_ascii", rx_if.ascii, 8'h41);
    pop1();
    chk("t1_ready_after_pop", rx_if.ready, 0);
    chk("t1_scan_after_pop", rx_if.scan_code, 0);
    chk("t1_ascii_after_pop", rx_if.ascii, 0);

    // 2: make, pop, break sequence pushes nothing
    base = ferr_cnt;
    send_frame(8'h1C, 0, 0);
    pop1();
    chk("t2_popped", rx_if.ready, 0);
    send_frame(8'hF0, 0, 0);
    send_frame(8'h1C, 0, 0);
    repeat (20) @(negedge clk);
    chk("t2_release_no_push", rx_if.ready, 0);
    chk("t2_no_ferr", ferr_cnt - base, 0);

    // 3: extended key and extended release
    send_frame(8'hE0, 0, 0);
    send_frame(8'h75, 0, 0);
    chk("t3_ext_scan", rx_if.scan_code, 8'h75);
    chk("t3_ext_ascii", rx_if.ascii, 0);
    send_frame(8'hE0, 0, 0);
    send_frame(8'hF0, 0, 0);
    send_frame(8'h75, 0, 0);
    pop1();
    chk("t3_single_entry", rx_if.ready, 0);
    send_frame(8'h16, 0, 0);
    chk("t3_ext_cleared", rx_if.ascii, 8'h31);
    pop1();

    // 4: parity error
    base = ferr_cnt;
    send_frame(8'h1C, 1, 0);
    repeat (10) @(negedge clk);
    chk("t4_ferr_one_cycle", ferr_cnt - base, 1);
    chk("t4_no_push", rx_if.ready, 0);
    send_frame(8'h32, 0, 0);
    chk("t4_recover_ascii", rx_if.ascii, 8'h42);
    pop1();

    // 5a: overflow with nine pushes and no pops
    for (int i = 0; i < 9; i++) begin
      send_frame(codes[i], 0, 0);
      if (i == 7) chk("t5_no_ovf_at_8", rx_if.overflow, 0);
    end
    chk("t5_ovf_set", rx_if.overflow, 1);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("t5_order_%0d", i), rx_if.ascii, chars[i]);
      pop1();
    end
    chk("t5_ninth_dropped", rx_if.ready, 0);
    chk("t5_ovf_sticky", rx_if.overflow, 1);

    // 5b: push coinciding with pop on a full FIFO
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    chk("t5b_ovf_cleared", rx_if.overflow, 0);
    for (int i = 0; i < 8; i++) send_frame(codes[i], 0, 0);
    send_frame(codes[8], 0, 1);
    chk("t5b_no_ovf", rx_if.overflow, 0);
    chk("t5b_head_w", rx_if.ascii, 8'h57);
    for (int i = 0; i < 8; i++) pop1();
    chk("t5b_eight_entries", rx_if.ready, 0);

    // 6a: partial frame then silence
    base = ferr_cnt;
    ps2_bit(1'b0, 0, 0);
    ps2_bit(1'b1, 0, 0);
    ps2_bit(1'b0, 0, 0);
    ps2_bit(1'b1, 0, 0);
    @(negedge clk); ps2_data = 1'b1;
    repeat (4) @(negedge clk);
    ps2_clk = 1'b0;
    t = 0;
    for (int i = 1; i <= TO + 20; i++) begin
      @(posedge clk); #1;
      if (rx_if.frame_err === 1'b1 && t == 0) t = i;
      if (i == 10) ps2_clk = 1'b1;
    end
    chk("t6_timeout_latency", (t >= TO + 1 && t <= TO + 5), 1);
    chk("t6_timeout_pulse", ferr_cnt - base, 1);
    chk("t6_no_push", rx_if.ready, 0);
    send_frame(8'h45, 0, 0);
    chk("t6_after_timeout", rx_if.ascii, 8'h30);

    // 6b: reset in the middle of a frame
    chk("t6_ready_before_rst", rx_if.ready, 1);
    ps2_bit(1'b0, 0, 0);
    ps2_bit(1'b1, 0, 0);
    ps2_bit(1'b1, 0, 0);
    @(negedge clk); rst = 1'b1;
    #1;
    chk("t6_rst_ready", rx_if.ready, 0);
    chk("t6_rst_scan", rx_if.scan_code, 0);
    chk("t6_rst_ascii", rx_if.ascii, 0);
    chk("t6_rst_ferr", rx_if.frame_err, 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    send_frame(8'h32, 0, 0);
    chk("t6_clean_after_rst", rx_if.ascii, 8'h42);

    $display("%0d/%0d checks passed", n_total - n_fail, n_total);
    $finish;
  end
endmodule
